// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: write-mode
// encodings, default geometry and the address-width derivation.
package regfile_pkg;

    // Write-mode encodings carried on wr_mode
    localparam logic [1:0] WMODE_FULL = 2'b00;
    localparam logic [1:0] WMODE_LLB  = 2'b01;
    localparam logic [1:0] WMODE_LHB  = 2'b10;
    localparam logic [1:0] WMODE_RSVD = 2'b11;

    // Default geometry
    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREGS  = 16;

    // Address width needed to index nregs registers (at least one bit)
    function automatic int calc_addr_w(input int nregs);
        if (nregs > 1) begin
            return $clog2(nregs);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by decode claims
// and cleared by writeback commits, plus a registered count of busy entries.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = DEF_NREGS,
    localparam int ADDR_W = calc_addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [NREGS-1:0]  busy,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;
    logic [ADDR_W:0]  cnt_r;
    logic [ADDR_W:0]  cnt_next_s;

    // Next busy vector: clear first, then set, so a claim on the same edge
    // as a retiring write leaves the register busy for the new producer.
    // Register 0 is never claimable.
    always_comb begin
        busy_next_s = busy_r;
        if (clr_en) begin
            busy_next_s[clr_addr] = 1'b0;
        end else begin
            busy_next_s = busy_r;
        end
        if (set_en && (set_addr != {ADDR_W{1'b0}})) begin
            busy_next_s[set_addr] = 1'b1;
        end else begin
            busy_next_s[0] = busy_next_s[0];
        end
    end

    // Population count of the next busy vector, registered alongside it
    always_comb begin
        cnt_next_s = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt_next_s = cnt_next_s + (ADDR_W+1)'(busy_next_s[i]);
        end
    end

    // Busy vector and pending count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREGS{1'b0}};
            cnt_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r <= busy_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    assign busy        = busy_r;
    assign pending_cnt = cnt_r;

endmodule

// File: rtl/regfile_param.sv
// General-purpose register file with configurable width, depth and read
// ports, half-word writes, optional write-to-read bypass and a pending-write
// scoreboard that flags read hazards to decode.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int ADDR_W = calc_addr_w(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_hazard,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [1:0]            wr_mode,
    input  logic                  claim_en,
    input  logic [ADDR_W-1:0]     claim_addr,
    output logic [ADDR_W:0]       pending_cnt
);

    localparam int HALF = DATA_W / 2;

    logic [DATA_W-1:0] mem_r [NREGS];
    logic              wr_valid_s;
    logic [DATA_W-1:0] wr_cur_s;
    logic [DATA_W-1:0] wr_merged_s;
    logic [NREGS-1:0]  busy_s;

    // A write commits only to a nonzero register with a defined mode
    always_comb begin
        if (wr_en && (wr_addr != {ADDR_W{1'b0}}) && (wr_mode != WMODE_RSVD)) begin
            wr_valid_s = 1'b1;
        end else begin
            wr_valid_s = 1'b0;
        end
    end

    // Merge the incoming half/full word with the current register contents;
    // both half modes take their payload from the low half of wr_data
    always_comb begin
        wr_cur_s = mem_r[wr_addr];
        case (wr_mode)
            WMODE_FULL: wr_merged_s = wr_data;
            WMODE_LLB:  wr_merged_s = {wr_cur_s[DATA_W-1:HALF], wr_data[HALF-1:0]};
            WMODE_LHB:  wr_merged_s = {wr_data[HALF-1:0], wr_cur_s[HALF-1:0]};
            default:    wr_merged_s = wr_cur_s;
        endcase
    end

    // Register storage; entry 0 is only ever written by reset so it reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_valid_s) begin
            mem_r[wr_addr] <= wr_merged_s;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (claim_en),
        .set_addr    (claim_addr),
        .clr_en      (wr_valid_s),
        .clr_addr    (wr_addr),
        .busy        (busy_s),
        .pending_cnt (pending_cnt)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              hit_s;
        logic [DATA_W-1:0] data_s;
        logic              hazard_s;

        // Per-port read mux with bypass of the in-flight write; outputs are
        // forced quiet while reset is held so a concurrent write cannot leak
        always_comb begin
            addr_s = rd_addr[p*ADDR_W +: ADDR_W];
            hit_s  = (BYPASS != 0) && wr_valid_s && (wr_addr == addr_s);
            if (!rst_n) begin
                data_s   = {DATA_W{1'b0}};
                hazard_s = 1'b0;
            end else if (hit_s) begin
                data_s   = wr_merged_s;
                hazard_s = 1'b0;
            end else begin
                data_s   = mem_r[addr_s];
                hazard_s = busy_s[addr_s];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_s;
        assign rd_hazard[p]                = hazard_s;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a bypassing and a non-bypassing
// instance share stimulus; expected values are queued as stimulus is driven
// and drained against the outputs mid-cycle.
module tb_regfile_param;

    localparam int DW  = 16;
    localparam int NR  = 16;
    localparam int NRD = 2;
    localparam int AW  = 4;

    // Observation selectors
    localparam int S_D1P0 = 0;
    localparam int S_D1P1 = 1;
    localparam int S_H1P0 = 2;
    localparam int S_H1P1 = 3;
    localparam int S_PC1  = 4;
    localparam int S_D0P0 = 5;
    localparam int S_D0P1 = 6;
    localparam int S_H0P0 = 7;
    localparam int S_H0P1 = 8;
    localparam int S_PC0  = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data1, rd_data0;
    logic [NRD-1:0]    hz1, hz0;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [1:0]        wr_mode;
    logic              claim_en;
    logic [AW-1:0]     claim_addr;
    logic [AW:0]       pc1, pc0;

    int vectors     = 0;
    int miscompares = 0;

    int          sel_q [$];
    logic [31:0] val_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_hazard(hz1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mode(wr_mode), .claim_en(claim_en), .claim_addr(claim_addr),
        .pending_cnt(pc1)
    );

    regfile_param #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_hazard(hz0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mode(wr_mode), .claim_en(claim_en), .claim_addr(claim_addr),
        .pending_cnt(pc0)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_D1P0:  return {16'h0000, rd_data1[15:0]};
            S_D1P1:  return {16'h0000, rd_data1[31:16]};
            S_H1P0:  return {31'd0, hz1[0]};
            S_H1P1:  return {31'd0, hz1[1]};
            S_PC1:   return {27'd0, pc1};
            S_D0P0:  return {16'h0000, rd_data0[15:0]};
            S_D0P1:  return {16'h0000, rd_data0[31:16]};
            S_H0P0:  return {31'd0, hz0[0]};
            S_H0P1:  return {31'd0, hz0[1]};
            S_PC0:   return {27'd0, pc0};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [31:0] exp, input string tag);
        sel_q.push_back(sel);
        val_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        while (sel_q.size() > 0) begin
            int          s;
            logic [31:0] v;
            string       t;
            s = sel_q.pop_front();
            v = val_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, observe(s), v);
        end
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        wr_addr    = 4'd0;
        wr_data    = 16'h0000;
        wr_mode    = 2'b00;
        claim_en   = 1'b0;
        claim_addr = 4'd0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mode = m;
    endtask

    task automatic claim(input logic [AW-1:0] a);
        claim_en   = 1'b1;
        claim_addr = a;
    endtask

    // Advance one edge; inputs are changed on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rd(4'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. reset pulse mid-cycle with r5 written and busy
        claim(4'd5); wr(4'd5, 16'h5555, 2'b00); rd(4'd5, 4'd0);
        tick();
        idle(); rd(4'd5, 4'd0);
        #2;
        expect_val(S_D1P0, 32'h5555, "pre_rst_r5");
        expect_val(S_H1P0, 32'd1,    "pre_rst_hz");
        expect_val(S_PC1,  32'd1,    "pre_rst_pc");
        drain();
        #1 rst_n = 1'b0;
        #1;
        expect_val(S_D1P0, 32'h0, "rst_r5_byp");
        expect_val(S_D1P1, 32'h0, "rst_r0_byp");
        expect_val(S_H1P0, 32'd0, "rst_hz_byp");
        expect_val(S_PC1,  32'd0, "rst_pc_byp");
        expect_val(S_D0P0, 32'h0, "rst_r5_nob");
        expect_val(S_PC0,  32'd0, "rst_pc_nob");
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        expect_val(S_D1P0, 32'h0, "post_rst_r5");
        expect_val(S_PC1,  32'd0, "post_rst_pc");
        drain();
        tick();

        // 2. half-word writes
        idle(); wr(4'd3, 16'h1234, 2'b00); rd(4'd3, 4'd0);
        tick();
        idle(); wr(4'd3, 16'h00AB, 2'b01); rd(4'd3, 4'd3);
        #2;
        expect_val(S_D1P0, 32'h12AB, "llb_byp");
        expect_val(S_D0P0, 32'h1234, "llb_nob_old");
        expect_val(S_D0P1, 32'h1234, "llb_nob_old_p1");
        drain();
        tick();
        idle(); wr(4'd3, 16'h00CD, 2'b10); rd(4'd3, 4'd3);
        #2;
        expect_val(S_D1P0, 32'hCDAB, "lhb_byp");
        expect_val(S_D1P1, 32'hCDAB, "lhb_byp_p1");
        expect_val(S_D0P0, 32'h12AB, "llb_stored");
        drain();
        tick();
        idle(); wr(4'd3, 16'hFFFF, 2'b11); rd(4'd3, 4'd0);
        #2;
        expect_val(S_D1P0, 32'hCDAB, "rsvd_no_byp");
        expect_val(S_D0P0, 32'hCDAB, "lhb_stored");
        drain();
        tick();
        idle(); rd(4'd3, 4'd0);
        #2;
        expect_val(S_D1P0, 32'hCDAB, "rsvd_kept");
        expect_val(S_D0P0, 32'hCDAB, "rsvd_kept_nob");
        drain();

        // register 0 ignores writes, including through bypass
        wr(4'd0, 16'hFFFF, 2'b00); rd(4'd0, 4'd0);
        #1;
        expect_val(S_D1P0, 32'h0, "r0_byp");
        drain();
        tick();
        idle(); rd(4'd0, 4'd3);
        #2;
        expect_val(S_D1P0, 32'h0, "r0_after");
        expect_val(S_PC1,  32'd0, "r0_pc");
        drain();

        // 3. bypass vs. no bypass
        wr(4'd7, 16'hBEEF, 2'b00); rd(4'd7, 4'd7);
        #1;
        expect_val(S_D1P0, 32'hBEEF, "byp_new");
        expect_val(S_D0P0, 32'h0000, "nob_old");
        drain();
        tick();
        idle(); rd(4'd7, 4'd0);
        #2;
        expect_val(S_D0P0, 32'hBEEF, "nob_next");
        expect_val(S_D1P0, 32'hBEEF, "byp_next");
        drain();

        // 4. scoreboard claim / retire
        claim(4'd4); rd(4'd4, 4'd0);
        #1;
        expect_val(S_H1P0, 32'd0, "claim_not_yet");
        drain();
        tick();
        idle(); rd(4'd4, 4'd0);
        #2;
        expect_val(S_H1P0, 32'd1, "claim_hz_byp");
        expect_val(S_H0P0, 32'd1, "claim_hz_nob");
        expect_val(S_PC1,  32'd1, "claim_pc_byp");
        expect_val(S_PC0,  32'd1, "claim_pc_nob");
        drain();
        wr(4'd4, 16'h4444, 2'b00);
        #1;
        expect_val(S_H1P0, 32'd0, "wr_hz_drop_byp");
        expect_val(S_H0P0, 32'd1, "wr_hz_hold_nob");
        expect_val(S_PC1,  32'd1, "wr_pc_same");
        drain();
        tick();
        idle();
        #2;
        expect_val(S_H1P0, 32'd0,     "ret_hz_byp");
        expect_val(S_H0P0, 32'd0,     "ret_hz_nob");
        expect_val(S_PC1,  32'd0,     "ret_pc_byp");
        expect_val(S_PC0,  32'd0,     "ret_pc_nob");
        expect_val(S_D0P0, 32'h4444,  "ret_data");
        drain();

        // reserved mode does not retire a pending write
        claim(4'd8);
        tick();
        idle(); wr(4'd8, 16'hFFFF, 2'b11); rd(4'd8, 4'd0);
        #2;
        expect_val(S_H1P0, 32'd1, "rsvd_hz_byp");
        expect_val(S_H0P0, 32'd1, "rsvd_hz_nob");
        drain();
        tick();
        idle(); rd(4'd8, 4'd0);
        #2;
        expect_val(S_H1P0, 32'd1,   "rsvd_busy");
        expect_val(S_PC1,  32'd1,   "rsvd_pc");
        expect_val(S_D1P0, 32'h0,   "rsvd_nodata");
        drain();
        wr(4'd8, 16'h0808, 2'b01);
        tick();
        idle();
        #2;
        expect_val(S_PC1,  32'd0,     "llb_ret_pc");
        expect_val(S_PC0,  32'd0,     "llb_ret_pc_nob");
        expect_val(S_D1P0, 32'h0008,  "llb_r8");
        drain();

        // 5. collisions
        claim(4'd6); wr(4'd6, 16'h6666, 2'b00);
        tick();
        idle(); rd(4'd6, 4'd0);
        #2;
        expect_val(S_H1P0, 32'd1,     "coll_set_wins");
        expect_val(S_H0P0, 32'd1,     "coll_set_wins_nob");
        expect_val(S_PC1,  32'd1,     "coll_pc");
        expect_val(S_D1P0, 32'h6666,  "coll_data");
        drain();
        claim(4'd9);
        tick();
        idle(); claim(4'd2); wr(4'd9, 16'h9999, 2'b00);
        tick();
        idle(); rd(4'd2, 4'd9);
        #2;
        expect_val(S_H1P0, 32'd1, "diff_busy2");
        expect_val(S_H1P1, 32'd0, "diff_busy9");
        expect_val(S_H0P1, 32'd0, "diff_busy9_nob");
        expect_val(S_PC1,  32'd2, "diff_pc");
        expect_val(S_PC0,  32'd2, "diff_pc_nob");
        drain();
        claim(4'd0); rd(4'd0, 4'd6);
        tick();
        idle(); rd(4'd0, 4'd6);
        #2;
        expect_val(S_H1P0, 32'd0, "claim_r0_hz");
        expect_val(S_H1P1, 32'd1, "r6_still");
        expect_val(S_PC1,  32'd2, "claim_r0_pc");
        drain();
        claim(4'd6);
        tick();
        idle();
        #2;
        expect_val(S_PC1, 32'd2, "reclaim_pc");
        drain();

        // 6. reset during active write and claim
        claim(4'd1); wr(4'd2, 16'h2222, 2'b00);
        tick();
        idle(); claim(4'd3); wr(4'd1, 16'h1111, 2'b00);
        tick();
        idle(); rd(4'd1, 4'd2);
        #2;
        expect_val(S_D1P0, 32'h1111, "pre_r1");
        expect_val(S_D1P1, 32'h2222, "pre_r2");
        expect_val(S_PC1,  32'd2,    "pre_pc");
        drain();
        wr(4'd1, 16'hAAAA, 2'b00); claim(4'd3);
        #1 rst_n = 1'b0;
        #1;
        expect_val(S_D1P0, 32'h0, "mid_rst_r1");
        expect_val(S_D1P1, 32'h0, "mid_rst_r2");
        expect_val(S_H1P0, 32'd0, "mid_rst_hz0");
        expect_val(S_H1P1, 32'd0, "mid_rst_hz1");
        expect_val(S_PC1,  32'd0, "mid_rst_pc");
        expect_val(S_D0P0, 32'h0, "mid_rst_r1_nob");
        expect_val(S_PC0,  32'd0, "mid_rst_pc_nob");
        drain();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); rd(4'd3, 4'd6);
        #2;
        expect_val(S_H1P0, 32'd0, "rel_hz3");
        expect_val(S_H1P1, 32'd0, "rel_hz6");
        expect_val(S_PC1,  32'd0, "rel_pc");
        expect_val(S_PC0,  32'd0, "rel_pc_nob");
        expect_val(S_D1P0, 32'h0, "rel_r3");
        drain();
        tick();
        rd(4'd1, 4'd6);
        #2;
        expect_val(S_D1P0, 32'h0, "rel_r1");
        expect_val(S_H1P1, 32'd0, "rel_hz6_late");
        expect_val(S_PC1,  32'd0, "rel_pc_late");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
